// File: rtl/collision_detect.sv
// -----------------------------------------------------------------------------
// collision_detect
//
// Purpose:
//   Decides when a round of the flappy-bird game ends. The bird has a fixed X
//   position and a variable top row (Bird_Y). Each game tick the block compares
//   the bird box against the current pipe, the ground and (optionally) the
//   current coin. A hit is declared only after HIT_CONFIRM consecutive overlap
//   ticks, so that single-tick glitches from the renderer do not end a round.
//
//   State machine (one-hot, exported on Q_Idle/Q_Run/Q_Hit):
//     IDLE --Start--> RUN --confirmed overlap--> HIT --Ack--> IDLE
//
// Configuration:
//   COIN_COLLECT_EN  when defined, coin overlap is counted into Coins
//                    (saturating at 15) and Coin_Taken tells the renderer to
//                    hide the coin that was just collected. When undefined,
//                    Coins and Coin_Taken are tied to 0 and the coin inputs
//                    are ignored.
//
// Ports:
//   clk           in   1   game tick clock
//   reset         in   1   asynchronous, active-high
//   Start         in   1   begin a round (only honoured in IDLE)
//   Ack           in   1   acknowledge end of round (only honoured in HIT)
//   X_Edge_L/R    in   10  current pipe left/right X
//   Gap_Top/Bot   in   10  first/last open Y row of the pipe gap
//   Bird_Y        in   10  bird top Y
//   Coin_L/R/Y    in   10  current coin left/right X and top Y
//   shift_Coin    in   1   pulse: the coin index advanced to a new coin
//   Stop          out  1   round over, held until Ack
//   Hit_Pipe      out  1   latched: round ended on a pipe overlap
//   Hit_Floor     out  1   latched: round ended on a floor overlap
//   Coins         out  4   coins collected in this round
//   Coin_Taken    out  1   current coin already collected
//   Q_Idle/Run/Hit out 1   one-hot state
// -----------------------------------------------------------------------------
module collision_detect #(
   parameter int BIRD_X_L    = 200,
   parameter int BIRD_W      = 30,
   parameter int BIRD_H      = 24,
   parameter int FLOOR_Y     = 440,
   parameter int COIN_H      = 20,
   parameter int HIT_CONFIRM = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Start,
   input  logic       Ack,
   input  logic [9:0] X_Edge_L,
   input  logic [9:0] X_Edge_R,
   input  logic [9:0] Gap_Top,
   input  logic [9:0] Gap_Bot,
   input  logic [9:0] Bird_Y,
   input  logic [9:0] Coin_L,
   input  logic [9:0] Coin_R,
   input  logic [9:0] Coin_Y,
   input  logic       shift_Coin,
   output logic       Stop,
   output logic       Hit_Pipe,
   output logic       Hit_Floor,
   output logic [3:0] Coins,
   output logic       Coin_Taken,
   output logic       Q_Idle,
   output logic       Q_Run,
   output logic       Q_Hit
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_RUN  = 3'b010,
      ST_HIT  = 3'b100
   } state_t;

   // All geometry is evaluated 11 bits wide so that Bird_Y + BIRD_H cannot
   // wrap back into the visible range near the bottom of the 10-bit space.
   localparam logic [10:0] BIRD_L_C  = 11'(BIRD_X_L);
   localparam logic [10:0] BIRD_R_C  = 11'(BIRD_X_L + BIRD_W - 1);
   localparam logic [10:0] BIRD_H_C  = 11'(BIRD_H);
   localparam logic [10:0] FLOOR_C   = 11'(FLOOR_Y);
   localparam logic [10:0] COIN_H_C  = 11'(COIN_H);
   localparam logic [2:0]  CONFIRM_C = 3'(HIT_CONFIRM);

   // --------------------------------------------------------------------------
   // Overlap terms (combinational)
   // --------------------------------------------------------------------------
   logic [10:0] bird_top_w;
   logic [10:0] bird_bot_w;
   logic        pipe_x_ov;
   logic        pipe_y_ov;
   logic        pipe_ov;
   logic        floor_ov;
   logic        any_ov;

   assign bird_top_w = {1'b0, Bird_Y};
   assign bird_bot_w = bird_top_w + BIRD_H_C - 11'd1;

   assign pipe_x_ov = ({1'b0, X_Edge_L} <= BIRD_R_C) && ({1'b0, X_Edge_R} >= BIRD_L_C);
   // The bird is inside a pipe column unless it fits entirely within the gap.
   assign pipe_y_ov = (bird_top_w < {1'b0, Gap_Top}) || (bird_bot_w > {1'b0, Gap_Bot});
   assign pipe_ov   = pipe_x_ov && pipe_y_ov;
   assign floor_ov  = (bird_top_w + BIRD_H_C) > FLOOR_C;
   assign any_ov    = pipe_ov || floor_ov;

   // --------------------------------------------------------------------------
   // Round state machine with hit confirmation
   // --------------------------------------------------------------------------
   state_t     state_q,     state_d;
   logic [2:0] cnt_q,       cnt_d;
   logic       hit_pipe_q,  hit_pipe_d;
   logic       hit_floor_q, hit_floor_d;
   logic       start_round;

   assign start_round = (state_q == ST_IDLE) && Start;

   always_comb begin
      // NOTE: every signal gets a default before the case so that a path
      // which does not assign it holds the flop value instead of inferring a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      hit_pipe_d  = hit_pipe_q;
      hit_floor_d = hit_floor_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d     = ST_RUN;
               cnt_d       = 3'd0;
               hit_pipe_d  = 1'b0;
               hit_floor_d = 1'b0;
            end
         end

         ST_RUN: begin
            if (any_ov) begin
               // Leave for HIT on the edge where the streak would reach the
               // threshold; the cause flags capture this tick's overlap terms.
               if (cnt_q + 3'd1 == CONFIRM_C) begin
                  state_d     = ST_HIT;
                  cnt_d       = 3'd0;
                  hit_pipe_d  = pipe_ov;
                  hit_floor_d = floor_ov;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end else begin
               cnt_d = 3'd0;
            end
         end

         ST_HIT: begin
            if (Ack) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            // Recover from a corrupted one-hot code.
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         hit_pipe_q  <= 1'b0;
         hit_floor_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hit_pipe_q  <= hit_pipe_d;
         hit_floor_q <= hit_floor_d;
      end
   end

   assign Q_Idle    = state_q[0];
   assign Q_Run     = state_q[1];
   assign Q_Hit     = state_q[2];
   assign Stop      = state_q[2];
   assign Hit_Pipe  = hit_pipe_q;
   assign Hit_Floor = hit_floor_q;

   // --------------------------------------------------------------------------
   // Coin collection
   // --------------------------------------------------------------------------
`ifdef COIN_COLLECT_EN
   logic       coin_ov;
   logic       in_run;
   logic [3:0] coins_q,      coins_d;
   logic       coin_taken_q, coin_taken_d;

   assign in_run  = (state_q == ST_RUN);
   assign coin_ov = ({1'b0, Coin_L} <= BIRD_R_C) &&
                    ({1'b0, Coin_R} >= BIRD_L_C) &&
                    ({1'b0, Coin_Y} <= bird_bot_w) &&
                    (({1'b0, Coin_Y} + COIN_H_C - 11'd1) >= bird_top_w);

   always_comb begin
      coins_d      = coins_q;
      coin_taken_d = coin_taken_q;

      if (start_round) begin
         coins_d      = 4'd0;
         coin_taken_d = 1'b0;
      end

      // A new coin index always re-arms collection, and the old coin's
      // overlap must not be credited on the tick the index moves.
      if (shift_Coin) begin
         coin_taken_d = 1'b0;
      end else if (in_run && coin_ov && !coin_taken_q) begin
         if (coins_q != 4'hF) begin
            coins_d = coins_q + 4'd1;
         end
         coin_taken_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coins_q      <= 4'd0;
         coin_taken_q <= 1'b0;
      end else begin
         coins_q      <= coins_d;
         coin_taken_q <= coin_taken_d;
      end
   end

   assign Coins      = coins_q;
   assign Coin_Taken = coin_taken_q;
`else
   // Coin inputs are intentionally ignored in this build.
   logic unused_coin;
   assign unused_coin = ^{Coin_L, Coin_R, Coin_Y, shift_Coin, COIN_H_C};

   assign Coins      = 4'd0;
   assign Coin_Taken = 1'b0;
`endif

endmodule

// File: tb/tb_collision_detect.sv
// -----------------------------------------------------------------------------
// tb_collision_detect
//
// Self-checking bench for collision_detect: a table of directed per-tick
// vectors for hit detection, hand-written sequences for coins and
// asynchronous reset, and a randomized run against a behavioural model.
// Coin expectations follow COIN_COLLECT_EN so the bench works on both builds.
// -----------------------------------------------------------------------------
module tb_collision_detect;

   localparam int P_BIRD_X_L    = 200;
   localparam int P_BIRD_W      = 30;
   localparam int P_BIRD_H      = 24;
   localparam int P_FLOOR_Y     = 440;
   localparam int P_COIN_H      = 20;
   localparam int P_HIT_CONFIRM = 2;

`ifdef COIN_COLLECT_EN
   localparam bit COIN_ON = 1'b1;
`else
   localparam bit COIN_ON = 1'b0;
`endif

   localparam logic [2:0] IDL = 3'b001;
   localparam logic [2:0] RN  = 3'b010;
   localparam logic [2:0] HT  = 3'b100;

   logic       clk = 1'b0;
   logic       reset;
   logic       Start, Ack;
   logic [9:0] X_Edge_L, X_Edge_R, Gap_Top, Gap_Bot, Bird_Y;
   logic [9:0] Coin_L, Coin_R, Coin_Y;
   logic       shift_Coin;
   logic       Stop, Hit_Pipe, Hit_Floor;
   logic [3:0] Coins;
   logic       Coin_Taken, Q_Idle, Q_Run, Q_Hit;

   int total = 0;
   int bad   = 0;

   collision_detect #(
      .BIRD_X_L   (P_BIRD_X_L),
      .BIRD_W     (P_BIRD_W),
      .BIRD_H     (P_BIRD_H),
      .FLOOR_Y    (P_FLOOR_Y),
      .COIN_H     (P_COIN_H),
      .HIT_CONFIRM(P_HIT_CONFIRM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .Start     (Start),
      .Ack       (Ack),
      .X_Edge_L  (X_Edge_L),
      .X_Edge_R  (X_Edge_R),
      .Gap_Top   (Gap_Top),
      .Gap_Bot   (Gap_Bot),
      .Bird_Y    (Bird_Y),
      .Coin_L    (Coin_L),
      .Coin_R    (Coin_R),
      .Coin_Y    (Coin_Y),
      .shift_Coin(shift_Coin),
      .Stop      (Stop),
      .Hit_Pipe  (Hit_Pipe),
      .Hit_Floor (Hit_Floor),
      .Coins     (Coins),
      .Coin_Taken(Coin_Taken),
      .Q_Idle    (Q_Idle),
      .Q_Run     (Q_Run),
      .Q_Hit     (Q_Hit)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [2:0] q, input logic hp,
                             input logic hf, input int coins, input logic taken);
      check({tag, ".state"}, {29'd0, Q_Hit, Q_Run, Q_Idle}, {29'd0, q});
      check({tag, ".stop"}, {31'd0, Stop}, {31'd0, q[2]});
      check({tag, ".hit_pipe"}, {31'd0, Hit_Pipe}, {31'd0, hp});
      check({tag, ".hit_floor"}, {31'd0, Hit_Floor}, {31'd0, hf});
      check({tag, ".coins"}, {28'd0, Coins}, coins);
      check({tag, ".coin_taken"}, {31'd0, Coin_Taken}, {31'd0, taken});
   endtask

   function automatic int cexp(input int n);
      return COIN_ON ? n : 0;
   endfunction

   task automatic drive(input logic s, input logic a, input int xl, input int xr,
                        input int gt, input int gb, input int by, input int cl,
                        input int cr, input int cy, input logic sc);
      Start      = s;
      Ack        = a;
      X_Edge_L   = 10'(xl);
      X_Edge_R   = 10'(xr);
      Gap_Top    = 10'(gt);
      Gap_Bot    = 10'(gb);
      Bird_Y     = 10'(by);
      Coin_L     = 10'(cl);
      Coin_R     = 10'(cr);
      Coin_Y     = 10'(cy);
      shift_Coin = sc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------- vector table
   typedef struct {
      logic       start;
      logic       ack;
      int         xl, xr, gt, gb, by;
      int         reps;
      logic [2:0] q;
      logic       hp, hf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic s, input logic a, input int xl, input int xr,
                      input int by, input int reps, input logic [2:0] q,
                      input logic hp, input logic hf);
      vec_t v;
      v.start = s;  v.ack = a;
      v.xl = xl;    v.xr = xr;  v.gt = 100;  v.gb = 220;  v.by = by;
      v.reps = reps; v.q = q;   v.hp = hp;   v.hf = hf;
      tbl.push_back(v);
   endtask

   // -------------------------------------------------------- reference model
   bit m_on, m_stop, m_taken, m_hp, m_hf;
   int m_streak, m_coins;

   task automatic model_reset();
      m_on = 0; m_stop = 0; m_taken = 0; m_hp = 0; m_hf = 0;
      m_streak = 0; m_coins = 0;
   endtask

   task automatic model_step(input bit s, input bit a, input int xl, input int xr,
                             input int gt, input int gb, input int by, input int cl,
                             input int cr, input int cy, input bit sc);
      int bird_r, bird_b;
      bit pipe, floor_hit, coin;
      bird_r    = P_BIRD_X_L + P_BIRD_W - 1;
      bird_b    = by + P_BIRD_H - 1;
      pipe      = (xl <= bird_r) && (xr >= P_BIRD_X_L) && ((by < gt) || (bird_b > gb));
      floor_hit = (by + P_BIRD_H) > P_FLOOR_Y;
      coin      = (cl <= bird_r) && (cr >= P_BIRD_X_L) && (cy <= bird_b) &&
                  (cy + P_COIN_H - 1 >= by);
      if (!m_on) begin
         if (s) begin
            m_on = 1; m_stop = 0; m_streak = 0; m_coins = 0;
            m_taken = 0; m_hp = 0; m_hf = 0;
         end
      end else if (!m_stop) begin
         if (COIN_ON && !sc && coin && !m_taken) begin
            m_coins = (m_coins < 15) ? m_coins + 1 : 15;
            m_taken = 1;
         end
         if (pipe || floor_hit) begin
            m_streak++;
            if (m_streak >= P_HIT_CONFIRM) begin
               m_stop = 1; m_hp = pipe; m_hf = floor_hit; m_streak = 0;
            end
         end else begin
            m_streak = 0;
         end
      end else if (a) begin
         m_on = 0; m_stop = 0;
      end
      if (COIN_ON && sc) m_taken = 0;
   endtask

   function automatic logic [2:0] model_q();
      if (!m_on) return IDL;
      return m_stop ? HT : RN;
   endfunction

   // ------------------------------------------------------------------ test
   initial begin
      reset = 1'b1;
      drive(0, 0, 600, 650, 100, 220, 150, 600, 620, 0, 0);
      #3;
      expect_out("reset0", IDL, 0, 0, 0, 0);
      #9 reset = 1'b0;

      // Directed hit-detection vectors; coin kept far away.
      //   s  a  xl   xr   by    reps state hp hf
      add(0, 0, 600, 650, 150,  2,  IDL, 0, 0);
      add(0, 1, 600, 650, 150,  1,  IDL, 0, 0);   // Ack ignored in IDLE
      add(1, 0, 600, 650, 150,  1,  RN,  0, 0);
      add(1, 0, 190, 250, 150, 10,  RN,  0, 0);   // safe in gap, Start ignored
      add(0, 0, 190, 250, 210,  1,  RN,  0, 0);   // overlap / clear / overlap
      add(0, 0, 190, 250, 150,  1,  RN,  0, 0);
      add(0, 0, 190, 250, 210,  1,  RN,  0, 0);
      add(0, 0, 190, 250, 150,  1,  RN,  0, 0);
      add(0, 0, 230, 250, 210,  3,  RN,  0, 0);   // pipe just right of bird
      add(0, 0, 100, 199, 210,  3,  RN,  0, 0);   // pipe just left of bird
      add(0, 0, 190, 250, 197,  3,  RN,  0, 0);   // bottom on last gap row
      add(0, 0, 190, 250, 100,  3,  RN,  0, 0);   // top on first gap row
      add(0, 0, 600, 650, 416,  3,  RN,  0, 0);   // bottom on last sky row
      add(0, 0, 229, 240, 210,  1,  RN,  0, 0);   // left edge touches bird
      add(0, 0, 229, 240, 210,  1,  HT,  1, 0);
      add(0, 0, 229, 240, 210,  2,  HT,  1, 0);
      add(1, 0, 229, 240, 210,  1,  HT,  1, 0);   // Start ignored in HIT
      add(0, 1, 229, 240, 210,  1,  IDL, 1, 0);
      add(0, 0, 600, 650, 150,  1,  IDL, 1, 0);   // cause held after Ack
      add(1, 0, 600, 650, 417,  1,  RN,  0, 0);   // Start clears cause
      add(0, 0, 600, 650, 417,  1,  RN,  0, 0);
      add(0, 0, 600, 650, 417,  1,  HT,  0, 1);
      add(0, 1, 600, 650, 417,  1,  IDL, 0, 1);
      add(1, 0, 600, 650, 150,  1,  RN,  0, 0);
      add(0, 0, 100, 200, 430,  1,  RN,  0, 0);   // right edge touches bird
      add(0, 0, 100, 200, 430,  1,  HT,  1, 1);   // pipe and floor together
      add(0, 1, 100, 200, 430,  1,  IDL, 1, 1);
      add(1, 0, 600, 650, 150,  1,  RN,  0, 0);
      add(0, 0, 600, 650, 1010, 1,  RN,  0, 0);   // sum past 1023
      add(0, 0, 600, 650, 1010, 1,  HT,  0, 1);
      add(0, 1, 600, 650, 1010, 1,  IDL, 0, 1);
      add(1, 0, 600, 650, 150,  1,  RN,  0, 0);
      add(0, 0, 190, 250, 99,   1,  RN,  0, 0);   // one row above gap
      add(0, 0, 190, 250, 99,   1,  HT,  1, 0);
      add(0, 1, 190, 250, 99,   1,  IDL, 1, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].start, tbl[i].ack, tbl[i].xl, tbl[i].xr, tbl[i].gt, tbl[i].gb,
               tbl[i].by, 600, 620, 0, 0);
         for (int r = 0; r < tbl[i].reps; r++) begin
            tick();
            expect_out($sformatf("vec%0d", i), tbl[i].q, tbl[i].hp, tbl[i].hf, 0, 0);
         end
      end

      // Coin counting, re-arm and saturation.
      drive(1, 0, 600, 650, 100, 220, 150, 600, 620, 0, 0);
      tick(); expect_out("coin_start", RN, 0, 0, 0, 0);
      drive(0, 0, 600, 650, 100, 220, 150, 205, 224, 150, 0);
      for (int r = 0; r < 5; r++) begin
         tick(); expect_out($sformatf("coin_hold%0d", r), RN, 0, 0, cexp(1), COIN_ON);
      end
      shift_Coin = 1;
      tick(); expect_out("coin_shift", RN, 0, 0, cexp(1), 0);
      shift_Coin = 0;
      tick(); expect_out("coin_second", RN, 0, 0, cexp(2), COIN_ON);
      for (int i = 0; i < 20; i++) begin
         shift_Coin = 1;
         tick(); expect_out($sformatf("sat_shift%0d", i), RN, 0, 0, cexp((i + 2 > 15) ? 15 : i + 2), 0);
         shift_Coin = 0;
         tick(); expect_out($sformatf("sat_take%0d", i), RN, 0, 0, cexp((i + 3 > 15) ? 15 : i + 3), COIN_ON);
      end

      // Coin boundaries, coin on the hit edge, no counting in HIT.
      reset = 1; #2 reset = 0;
      drive(1, 0, 600, 650, 100, 220, 150, 600, 620, 0, 0);
      tick(); expect_out("b_start", RN, 0, 0, 0, 0);
      drive(0, 0, 600, 650, 100, 220, 150, 205, 224, 174, 0);
      tick(); expect_out("b_below", RN, 0, 0, 0, 0);
      drive(0, 0, 600, 650, 100, 220, 150, 205, 224, 130, 0);
      tick(); expect_out("b_above", RN, 0, 0, 0, 0);
      drive(0, 0, 600, 650, 100, 220, 150, 229, 248, 131, 0);
      tick(); expect_out("b_touch", RN, 0, 0, cexp(1), COIN_ON);
      shift_Coin = 1;
      tick(); expect_out("b_shift", RN, 0, 0, cexp(1), 0);
      drive(0, 0, 600, 650, 100, 220, 150, 230, 249, 150, 0);
      tick(); expect_out("b_right", RN, 0, 0, cexp(1), 0);
      drive(0, 0, 190, 250, 100, 220, 210, 600, 620, 0, 0);
      tick(); expect_out("b_pipe1", RN, 0, 0, cexp(1), 0);
      drive(0, 0, 190, 250, 100, 220, 210, 180, 200, 210, 0);
      tick(); expect_out("b_hit_coin", HT, 1, 0, cexp(2), COIN_ON);
      shift_Coin = 1;
      tick(); expect_out("b_hit_shift", HT, 1, 0, cexp(2), 0);
      shift_Coin = 0;
      tick(); expect_out("b_hit_nocount", HT, 1, 0, cexp(2), 0);

      // Asynchronous reset in HIT, then restart.
      #2 reset = 1;
      #1 expect_out("async_rst", IDL, 0, 0, 0, 0);
      drive(1, 0, 190, 250, 100, 220, 210, 180, 200, 210, 0);
      tick(); expect_out("rst_held", IDL, 0, 0, 0, 0);
      #2 reset = 0;
      Start = 0;
      tick(); expect_out("idle_nocoin", IDL, 0, 0, 0, 0);
      drive(1, 0, 600, 650, 100, 220, 150, 205, 224, 150, 0);
      tick(); expect_out("restart", RN, 0, 0, 0, 0);
      tick(); expect_out("restart_coin", RN, 0, 0, cexp(1), COIN_ON);

      // Randomized run against the model.
      reset = 1; #2 reset = 0;
      model_reset();
      for (int n = 0; n < 400; n++) begin
         int xl, xr, gt, gb, by, cl, cy;
         bit s, a, sc;
         xl = $urandom_range(140, 280);
         xr = xl + $urandom_range(0, 80);
         gt = $urandom_range(60, 260);
         gb = gt + $urandom_range(20, 160);
         by = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 1023) : $urandom_range(80, 460);
         cl = $urandom_range(170, 240);
         cy = by + $urandom_range(0, 60) - 30;
         if (cy < 0) cy = 0;
         if (cy > 1023) cy = 1023;
         s  = ($urandom_range(0, 3) == 0);
         a  = ($urandom_range(0, 4) == 0);
         sc = ($urandom_range(0, 7) == 0);
         drive(s, a, xl, xr, gt, gb, by, cl, cl + 19, cy, sc);
         model_step(s, a, xl, xr, gt, gb, by, cl, cl + 19, cy, sc);
         tick();
         expect_out($sformatf("rnd%0d", n), model_q(), m_hp, m_hf, m_coins, m_taken);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/collision_detect.md
COLLISION_DETECT -- requirements
Module: collision_detect

Interface
REQ-001 Parameter BIRD_X_L, 200, bird left edge (bird X is fixed).
REQ-002 Parameter BIRD_W, 30, bird width in pixels; bird right edge = BIRD_X_L+BIRD_W-1 = 229.
REQ-003 Parameter BIRD_H, 24, bird height in pixels.
REQ-004 Parameter FLOOR_Y, 440, first Y row of the ground.
REQ-005 Parameter COIN_H, 20, coin height in pixels.
REQ-006 Parameter HIT_CONFIRM, 2, consecutive overlap cycles required to declare a hit (range 1..7).
REQ-007 Ports, one per line:
- clk  in  1  game tick clock.
- reset  in  1  asynchronous, active-high.
- Start  in  1  begin a round.
- Ack  in  1  acknowledge end of round.
- X_Edge_L, X_Edge_R  in  10  current-pipe left/right X.
- Gap_Top, Gap_Bot  in  10  current-pipe gap first/last open Y row.
- Bird_Y  in  10  bird top Y.
- Coin_L, Coin_R, Coin_Y  in  10  current-coin left/right X, top Y.
- shift_Coin  in  1  one-cycle pulse: current coin index advanced.
- Stop  out  1  round over; held until Ack.
- Hit_Pipe, Hit_Floor  out  1  latched hit cause.
- Coins  out  4  coins collected this round.
- Coin_Taken  out  1  current coin already collected (renderer hides it).
- Q_Idle, Q_Run, Q_Hit  out  1  one-hot state.
REQ-008 One clock; reset is asynchronous and active-high; the ports are named clk and reset.

Function
REQ-009 States IDLE, RUN, HIT; one-hot encoding, exported on Q_Idle/Q_Run/Q_Hit.
REQ-010 IDLE: Start=1 -> RUN; on that edge clear Coins, Coin_Taken, Hit_Pipe, Hit_Floor and the confirm counter.
REQ-011 Pipe overlap (combinational) = X_Edge_L<=229 AND X_Edge_R>=200 AND (Bird_Y<Gap_Top OR Bird_Y+BIRD_H-1>Gap_Bot).
REQ-012 Floor overlap = Bird_Y+BIRD_H>FLOOR_Y.
REQ-013 All sums are computed 11 bits wide; no 10-bit wrap. X inputs up to 701 are legal.
REQ-014 RUN: the confirm counter increments each cycle pipe or floor overlap is true and clears to 0 on any cycle it is false.
REQ-015 RUN -> HIT on the edge where the counter would reach HIT_CONFIRM; Hit_Pipe/Hit_Floor latch the overlap terms sampled on that cycle (both may be 1).
REQ-016 Stop = Q_Hit; Stop therefore rises on the edge ending the HIT_CONFIRM-th consecutive overlap cycle.
REQ-017 HIT: Ack=1 -> IDLE; Stop drops on that edge. Hit_Pipe, Hit_Floor and Coins hold until the next Start.
REQ-018 Start is ignored outside IDLE; Ack is ignored outside HIT.
REQ-019 Coin overlap = Coin_L<=229 AND Coin_R>=200 AND Coin_Y<=Bird_Y+BIRD_H-1 AND Coin_Y+COIN_H-1>=Bird_Y.
REQ-020 RUN, coin overlap AND Coin_Taken=0 AND shift_Coin=0: Coins<=Coins+1, saturating at 15; Coin_Taken<=1.
REQ-021 shift_Coin=1 clears Coin_Taken in any state and blocks an increment on that cycle.
REQ-022 A coin increment and the RUN->HIT transition on the same edge are both performed.
REQ-023 No coin counting occurs in IDLE or HIT.

Reset
REQ-024 reset=1 immediately forces IDLE and clears Stop, Hit_Pipe, Hit_Floor, Coins, Coin_Taken and the confirm counter, with no clock edge required.
REQ-025 Reset mid-RUN or mid-HIT behaves identically to REQ-024; the first edge after release with Start=1 enters RUN.

Configuration
REQ-026 Macro COIN_COLLECT_EN defined: coin logic per REQ-019..REQ-023.
REQ-027 Macro COIN_COLLECT_EN undefined: no coin logic; Coins and Coin_Taken are tied to 0; coin inputs are unused; hit behaviour is unchanged.

Verification
REQ-028 The bench covers the following directed scenarios:
- Start, then pipe X 190..250, gap 100..220, Bird_Y=150 for 10 cycles -> Stop stays 0, Q_Run=1.
- Same pipe, Bird_Y=210 (bottom 233>220) held -> Stop=1 two edges after first overlap, Hit_Pipe=1, Hit_Floor=0; Ack -> Q_Idle=1 next edge.
- Overlap 1 cycle, clear 1 cycle, overlap 1 cycle (HIT_CONFIRM=2) -> no hit.
- Bird_Y=417 (417+24=441>440) -> Hit_Floor=1, Stop=1 after 2 edges.
- Coin X 205..224, Coin_Y=150, Bird_Y=150 for 5 cycles -> Coins=1 only; shift_Coin pulse -> Coin_Taken=0; next coin overlap -> Coins=2; 20 coins -> Coins=15 saturated.
- reset asserted in HIT -> Stop=0, Coins=0, Q_Idle=1 without a clock edge.
